// File: rtl/std_fp_pkg.sv
// Shared definitions for the signed fixed-point divider family:
// controller state encoding and saturation constants.
package std_fp_pkg;

    localparam int unsigned FP_MAX_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIX,
        ST_DONE
    } fp_state_e;

    // Most positive w-bit two's-complement value (0111..1), zero-extended.
    function automatic logic [FP_MAX_W-1:0] fp_max(input int unsigned w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (one << (w - 1)) - one;
    endfunction

    // Most negative w-bit two's-complement value (1000..0), zero-extended.
    function automatic logic [FP_MAX_W-1:0] fp_min(input int unsigned w);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/std_fp_udiv_step.sv
// One restoring-division step: shift the partial remainder left by one
// dividend bit, trial-subtract the divisor, keep the result if non-negative.
module std_fp_udiv_step #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 56
) (
    input  logic [WIDTH-1:0] part_i,
    input  logic [N-1:0]     acc_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] part_o,
    output logic [N-1:0]     acc_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    always_comb begin
        shifted = {part_i, acc_i[N-1]};
        diff    = shifted - {1'b0, dvs_i};
        qbit    = ~diff[WIDTH];
        part_o  = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        acc_o   = {acc_i[N-2:0], qbit};
    end

endmodule

// File: rtl/std_fp_sdiv_sat.sv
// Sequential signed fixed-point divider: one quotient bit per cycle,
// sign fix-up with optional saturation, divide-by-zero short path.
module std_fp_sdiv_sat
    import std_fp_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INT_WIDTH   = 8,
    parameter int unsigned FRACT_WIDTH = 24,
    parameter int unsigned SATURATE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH + FRACT_WIDTH;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0] QMIN = WIDTH'(fp_min(WIDTH));

    if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_width_check
        $error("std_fp_sdiv_sat: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
    end

    fp_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic             lneg_q, lneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_part;
    logic [N-1:0]     step_acc;
    logic [WIDTH-1:0] l_mag, r_mag, q_signed;
    logic             q_ovf;

    std_fp_udiv_step #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_step (
        .part_i (part_q),
        .acc_i  (acc_q),
        .dvs_i  (dvs_q),
        .part_o (step_part),
        .acc_o  (step_acc)
    );

    always_comb begin
        l_mag    = left[WIDTH-1]  ? -left  : left;
        r_mag    = right[WIDTH-1] ? -right : right;
        // A negative result may reach magnitude 2^(WIDTH-1); a positive one may not.
        q_ovf    = neg_q ? ((|acc_q[N-1:WIDTH]) || (acc_q[WIDTH-1] && (|acc_q[WIDTH-2:0])))
                         : (|acc_q[N-1:WIDTH-1]);
        q_signed = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        lneg_d  = lneg_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (right == '0) begin
                        state_d = ST_DONE;
                        quot_d  = left[WIDTH-1] ? QMIN : QMAX;
                        remo_d  = left;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CW'(N);
                        part_d  = '0;
                        acc_d   = {l_mag, {FRACT_WIDTH{1'b0}}};
                        dvs_d   = r_mag;
                        neg_d   = left[WIDTH-1] ^ right[WIDTH-1];
                        lneg_d  = left[WIDTH-1];
                    end
                end
            end
            ST_BUSY: begin
                part_d = step_part;
                acc_d  = step_acc;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quot_d  = (q_ovf && (SATURATE != 0)) ? (neg_q ? QMIN : QMAX) : q_signed;
                remo_d  = lneg_q ? -part_q : part_q;
                ovf_d   = q_ovf;
                dbz_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            lneg_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            lneg_q  <= lneg_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out_quotient  = quot_q;
    assign out_remainder = remo_q;
    assign done          = done_q;
    assign div_by_zero   = dbz_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_std_fp_sdiv_sat.sv
// Bench for std_fp_sdiv_sat (Q8.8): saturating and wrapping instances side by
// side, checked against an integer-arithmetic reference model.
module tb_std_fp_sdiv_sat;

    logic        clk;
    logic        reset;
    logic        go;
    logic [15:0] left, right;
    logic [15:0] q_s, r_s, q_w, r_w;
    logic        done_s, dz_s, ov_s, done_w, dz_w, ov_w;

    int n_checks = 0;
    int n_fail   = 0;

    std_fp_sdiv_sat #(
        .WIDTH       (16),
        .INT_WIDTH   (8),
        .FRACT_WIDTH (8),
        .SATURATE    (1)
    ) u_sat (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (q_s),
        .out_remainder (r_s),
        .done          (done_s),
        .div_by_zero   (dz_s),
        .overflow      (ov_s)
    );

    std_fp_sdiv_sat #(
        .WIDTH       (16),
        .INT_WIDTH   (8),
        .FRACT_WIDTH (8),
        .SATURATE    (0)
    ) u_wrap (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .left          (left),
        .right         (right),
        .out_quotient  (q_w),
        .out_remainder (r_w),
        .done          (done_w),
        .div_by_zero   (dz_w),
        .overflow      (ov_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: real-valued quotient of (left*256)/right with truncation toward zero.
    task automatic model(input logic [15:0] l, input logic [15:0] r, input bit sat,
                         output logic [15:0] q, output logic [15:0] rm,
                         output logic dz, output logic ov);
        longint lv, rv, num, qq, rr;
        lv = longint'($signed(l));
        rv = longint'($signed(r));
        if (rv == 0) begin
            q  = (lv >= 0) ? 16'h7FFF : 16'h8000;
            rm = l;
            dz = 1'b1;
            ov = 1'b0;
        end else begin
            num = lv * 256;
            qq  = num / rv;
            rr  = num % rv;
            ov  = (qq > 32767) || (qq < -32768);
            dz  = 1'b0;
            if (ov && sat) q = (qq > 0) ? 16'h7FFF : 16'h8000;
            else           q = qq[15:0];
            rm = rr[15:0];
        end
    endtask

    task automatic do_op(input logic [15:0] l, input logic [15:0] r);
        logic [15:0] eq_s, er_s, eq_w, er_w;
        logic        ed_s, eo_s, ed_w, eo_w;
        int          lat, exp_lat;
        bit          seen;
        model(l, r, 1'b1, eq_s, er_s, ed_s, eo_s);
        model(l, r, 1'b0, eq_w, er_w, ed_w, eo_w);
        exp_lat = (r == 16'h0000) ? 1 : 26;

        @(negedge clk);
        left  = l;
        right = r;
        go    = 1'b1;
        @(posedge clk);
        #1;
        go    = 1'($urandom);
        left  = 16'($urandom);
        right = 16'($urandom);
        lat   = 0;
        seen  = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_s) seen = 1'b1;
            else begin
                go    = 1'($urandom);
                left  = 16'($urandom);
                right = 16'($urandom);
            end
        end
        go = 1'b0;

        chk_int("latency", lat, exp_lat);
        chk1("done_wrap", done_w, 1'b1);
        chk16("quot_sat", q_s, eq_s);
        chk16("rem_sat", r_s, er_s);
        chk1("dbz_sat", dz_s, ed_s);
        chk1("ovf_sat", ov_s, eo_s);
        chk16("quot_wrap", q_w, eq_w);
        chk16("rem_wrap", r_w, er_w);
        chk1("dbz_wrap", dz_w, ed_w);
        chk1("ovf_wrap", ov_w, eo_w);

        @(posedge clk);
        #1;
        chk1("done_pulse_end", done_s, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk16("quot_hold", q_s, eq_s);
        chk16("rem_hold", r_s, er_s);
    endtask

    initial begin
        int          done_cnt;
        logic [15:0] rl, rr;

        reset = 1'b0;
        go    = 1'b0;
        left  = '0;
        right = '0;

        repeat (3) @(posedge clk);
        #1;
        chk16("rst_quot", q_s, 16'h0000);
        chk16("rst_rem", r_s, 16'h0000);
        chk1("rst_done", done_s, 1'b0);
        chk1("rst_dbz", dz_s, 1'b0);
        chk1("rst_ovf", ov_s, 1'b0);
        chk16("rst_quot_wrap", q_w, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        do_op(16'h0700, 16'h0200);
        do_op(16'hF900, 16'h0200);
        do_op(16'h6400, 16'h0080);
        do_op(16'h8000, 16'hFF00);
        do_op(16'hFE00, 16'h0000);
        do_op(16'h1234, 16'h0000);
        do_op(16'h0100, 16'h0300);
        do_op(16'hFF00, 16'h0300);
        do_op(16'h8000, 16'h0100);
        do_op(16'h0000, 16'hFD00);
        do_op(16'h7FFF, 16'h0001);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        left  = 16'h0700;
        right = 16'h0200;
        go    = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk16("midrst_quot", q_s, 16'h0000);
        chk16("midrst_rem", r_s, 16'h0000);
        chk1("midrst_ovf", ov_s, 1'b0);
        chk1("midrst_dbz", dz_s, 1'b0);
        done_cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done_s || done_w) done_cnt++;
        end
        chk_int("midrst_no_done", done_cnt, 0);
        reset = 1'b1;
        do_op(16'h0700, 16'h0200);

        repeat (30) begin
            rl = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rr = 16'h0000;
                1, 2:    rr = 16'($urandom_range(0, 255)) ^ {16{rl[0]}};
                default: rr = 16'($urandom);
            endcase
            do_op(rl, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
